match_referee: RTL and testbench
================================

Name: match_referee

Overview:
- Round controller that feeds the result/menu display stage.
- Owns both players' health and the round countdown timer, and decides the match outcome.
- Produces the 2-bit game_state the display stage consumes: 00 fight, 01 player 1 wins, 10 player 2 wins, 11 no result.
- Hit events come from the combat/collision logic; start comes from a debounced pushbutton.

Parameters:
- MAX_HEALTH, 100: health loaded into each player at round start (7-bit range).
- ROUND_SECS, 99: round length in seconds (7-bit range).
- TICK_DIV, 100_000_000: clk cycles per one-second tick. The bench overrides it, e.g. to 10.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  debounced start button, level. Only its rising edge is used.
- p1_hit  in  1  one-cycle pulse: player 1 landed a hit on player 2.
- p1_dmg  in  4  damage of the p1_hit, sampled when p1_hit=1.
- p2_hit  in  1  one-cycle pulse: player 2 landed a hit on player 1.
- p2_dmg  in  4  damage of the p2_hit, sampled when p2_hit=1.
- game_state  out  2  00 FIGHT, 01 P1_WIN, 10 P2_WIN, 11 NO_RESULT.
- p1_health  out  7  current player 1 health.
- p2_health  out  7  current player 2 health.
- time_left  out  7  seconds remaining in the round.
- round_over  out  1  one-cycle pulse on every FIGHT-to-result transition.

Behaviour:
- All outputs are registered.
- On rst assertion, asynchronously:
  - game_state=11, state IDLE.
  - p1_health=p2_health=MAX_HEALTH, time_left=ROUND_SECS.
  - round_over=0, tick counter=0, start edge register=0.
- Start edge detect: start_q <= start; start_rise = start & ~start_q.
- States and their game_state encoding: IDLE(11), FIGHT(00), P1_WIN(01), P2_WIN(10), DRAW(11).
- IDLE / P1_WIN / P2_WIN / DRAW, on start_rise:
  - go to FIGHT next cycle.
  - reload both healths to MAX_HEALTH and time_left to ROUND_SECS.
  - clear the tick counter.
  - Hits in these states are ignored.
- FIGHT, hits:
  - p1_hit subtracts p1_dmg from p2_health; p2_hit subtracts p2_dmg from p1_health.
  - Subtraction saturates at 0, no wrap.
  - Both hits in the same cycle are both applied that cycle.
  - dmg=0 with a hit pulse leaves health unchanged.
- FIGHT, timer:
  - Tick counter counts 0..TICK_DIV-1; at TICK_DIV-1 it wraps to 0 and time_left decrements by 1.
  - time_left never goes below 0.
- FIGHT, start_rise is ignored (no restart mid-round).
- FIGHT, outcome. Evaluated on the post-update health and timer values of the same cycle, with this priority:
  1. Both healths reach 0 in the same cycle -> DRAW.
  2. p2_health reaches 0 -> P1_WIN.
  3. p1_health reaches 0 -> P2_WIN.
  4. time_left reaches 0 -> higher health wins; equal health -> DRAW.
  - A knockout on the same cycle as the final tick is resolved as a knockout.
- Latency: a hit or tick at edge N shows on health/time_left after edge N. The resulting game_state change and round_over pulse appear on the same edge.
- Result states hold game_state, healths and time_left frozen until start_rise.
- rst asserted mid-round aborts immediately to the reset values. No round_over pulse is generated.

Test Plan:
- Reset/idle: assert rst; release; 20 cycles idle -> game_state=11, healths=100/100, time_left=99, round_over stays 0.
- Start and knockout: start rising edge, then 10 × p1_hit with dmg=10 -> game_state=00 after start. After the 10th hit p2_health=0, game_state=01, one round_over pulse. Later hits do not change health.
- Saturation and simultaneous knockout: set healths to 5/5 via hits, then one cycle with p1_hit (dmg 9) and p2_hit (dmg 15) -> both healths=0, game_state=11 (DRAW), round_over=1 for exactly one cycle.
- Timeout with TICK_DIV=10, ROUND_SECS=3: p2 hits p1 once for 4 -> time_left decrements every 10 cycles. At 0, game_state=10, healths 96/100 frozen.
- Timeout tie: no hits, TICK_DIV=10, ROUND_SECS=2 -> game_state=11 after 20 cycles in FIGHT.
- Start handling: start held high across the result state gives exactly one restart. start pulse during FIGHT has no effect. rst mid-FIGHT gives game_state=11 and full health the same cycle, with no round_over pulse.

Source files
------------

// File: rtl/match_referee_if.sv
// Round-controller bus: combat/button inputs toward the referee and the
// outcome/status fields it reports to the display stage.
interface match_referee_if;
  logic       start;
  logic       p1_hit;
  logic [3:0] p1_dmg;
  logic       p2_hit;
  logic [3:0] p2_dmg;
  logic [1:0] game_state;
  logic [6:0] p1_health;
  logic [6:0] p2_health;
  logic [6:0] time_left;
  logic       round_over;

  modport slave (
    input  start, p1_hit, p1_dmg, p2_hit, p2_dmg,
    output game_state, p1_health, p2_health, time_left, round_over
  );

  modport master (
    output start, p1_hit, p1_dmg, p2_hit, p2_dmg,
    input  game_state, p1_health, p2_health, time_left, round_over
  );
endinterface

// File: rtl/match_referee.sv
// Match referee: tracks both players' health and the round timer, and
// resolves the round outcome reported to the display stage.
module match_referee #(
  parameter int unsigned MAX_HEALTH = 100,
  parameter int unsigned ROUND_SECS = 99,
  parameter int unsigned TICK_DIV   = 100_000_000
) (
  input  logic            clk,
  input  logic            rst,
  match_referee_if.slave  bus
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [6:0] HEALTH_INIT = 7'(MAX_HEALTH);
  localparam logic [6:0] TIME_INIT   = 7'(ROUND_SECS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIGHT,
    ST_P1_WIN,
    ST_P2_WIN,
    ST_DRAW
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          game_state_q, game_state_d;
  logic [6:0]          p1_health_q, p1_health_d;
  logic [6:0]          p2_health_q, p2_health_d;
  logic [6:0]          time_left_q, time_left_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                round_over_q, round_over_d;
  logic                start_q;
  logic                start_rise;

  // Health never wraps below zero.
  function automatic logic [6:0] sat_sub(input logic [6:0] h, input logic [3:0] d);
    logic [6:0] dw;
    dw = 7'(d);
    return (h > dw) ? (h - dw) : 7'd0;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      game_state_q <= 2'b11;
      p1_health_q  <= HEALTH_INIT;
      p2_health_q  <= HEALTH_INIT;
      time_left_q  <= TIME_INIT;
      tick_q       <= '0;
      round_over_q <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      game_state_q <= game_state_d;
      p1_health_q  <= p1_health_d;
      p2_health_q  <= p2_health_d;
      time_left_q  <= time_left_d;
      tick_q       <= tick_d;
      round_over_q <= round_over_d;
      start_q      <= bus.start;
    end
  end

  always_comb begin
    state_d      = state_q;
    p1_health_d  = p1_health_q;
    p2_health_d  = p2_health_q;
    time_left_d  = time_left_q;
    tick_d       = tick_q;
    round_over_d = 1'b0;
    game_state_d = 2'b11;
    start_rise   = bus.start & ~start_q;

    case (state_q)
      ST_FIGHT: begin
        if (bus.p1_hit) p2_health_d = sat_sub(p2_health_q, bus.p1_dmg);
        if (bus.p2_hit) p1_health_d = sat_sub(p1_health_q, bus.p2_dmg);

        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (time_left_q != 7'd0) time_left_d = time_left_q - 7'd1;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end

        // Knockouts outrank the timer, even on the final tick.
        if ((p1_health_d == 7'd0) && (p2_health_d == 7'd0)) begin
          state_d = ST_DRAW;
        end else if (p2_health_d == 7'd0) begin
          state_d = ST_P1_WIN;
        end else if (p1_health_d == 7'd0) begin
          state_d = ST_P2_WIN;
        end else if (time_left_d == 7'd0) begin
          if (p1_health_d > p2_health_d)      state_d = ST_P1_WIN;
          else if (p2_health_d > p1_health_d) state_d = ST_P2_WIN;
          else                                state_d = ST_DRAW;
        end

        round_over_d = (state_d != ST_FIGHT);
      end
      default: begin
        if (start_rise) begin
          state_d     = ST_FIGHT;
          p1_health_d = HEALTH_INIT;
          p2_health_d = HEALTH_INIT;
          time_left_d = TIME_INIT;
          tick_d      = '0;
        end
      end
    endcase

    case (state_d)
      ST_FIGHT:  game_state_d = 2'b00;
      ST_P1_WIN: game_state_d = 2'b01;
      ST_P2_WIN: game_state_d = 2'b10;
      default:   game_state_d = 2'b11;
    endcase
  end

  assign bus.game_state = game_state_q;
  assign bus.p1_health  = p1_health_q;
  assign bus.p2_health  = p2_health_q;
  assign bus.time_left  = time_left_q;
  assign bus.round_over = round_over_q;

endmodule

// File: tb/tb_match_referee.sv
// Self-checking bench for match_referee: directed test-plan steps followed by
// randomized rounds, all compared against a round-level behavioural model.
module tb_match_referee;

  localparam int MAX   = 100;
  localparam int ROUND = 3;
  localparam int TICK  = 10;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Reference model: plain integers, time derived from elapsed fight cycles.
  int m_gs, m_h1, m_h2, m_time, m_fc, m_ro;
  bit m_sprev;

  match_referee_if bus ();

  match_referee #(
    .MAX_HEALTH(MAX),
    .ROUND_SECS(ROUND),
    .TICK_DIV  (TICK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_gs = 3; m_h1 = MAX; m_h2 = MAX; m_time = ROUND; m_fc = 0; m_ro = 0; m_sprev = 1'b0;
  endtask

  task automatic model_step();
    bit rise;
    rise    = bus.start & ~m_sprev;
    m_sprev = bus.start;
    m_ro    = 0;
    if (m_gs != 0) begin
      if (rise) begin
        m_gs = 0; m_h1 = MAX; m_h2 = MAX; m_time = ROUND; m_fc = 0;
      end
    end else begin
      if (bus.p2_hit) m_h1 = (m_h1 > int'(bus.p2_dmg)) ? m_h1 - int'(bus.p2_dmg) : 0;
      if (bus.p1_hit) m_h2 = (m_h2 > int'(bus.p1_dmg)) ? m_h2 - int'(bus.p1_dmg) : 0;
      m_fc++;
      m_time = ROUND - m_fc / TICK;
      if (m_time < 0) m_time = 0;
      if (m_h1 == 0 && m_h2 == 0) m_gs = 3;
      else if (m_h2 == 0)         m_gs = 1;
      else if (m_h1 == 0)         m_gs = 2;
      else if (m_time == 0)       m_gs = (m_h1 > m_h2) ? 1 : (m_h2 > m_h1) ? 2 : 3;
      if (m_gs != 0) m_ro = 1;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "/state"}, 8'(bus.game_state), 8'(m_gs));
    check({tag, "/p1h"},   8'(bus.p1_health),  8'(m_h1));
    check({tag, "/p2h"},   8'(bus.p2_health),  8'(m_h2));
    check({tag, "/time"},  8'(bus.time_left),  8'(m_time));
    check({tag, "/ro"},    8'(bus.round_over), 8'(m_ro));
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic set_hits(input bit h1, input int d1, input bit h2, input int d2);
    bus.p1_hit = h1; bus.p1_dmg = 4'(d1);
    bus.p2_hit = h2; bus.p2_dmg = 4'(d2);
  endtask

  // Reset takes effect without waiting for a clock edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "/rst_state"}, 8'(bus.game_state), 8'd3);
    check({tag, "/rst_p1h"},   8'(bus.p1_health),  8'(MAX));
    check({tag, "/rst_p2h"},   8'(bus.p2_health),  8'(MAX));
    check({tag, "/rst_time"},  8'(bus.time_left),  8'(ROUND));
    check({tag, "/rst_ro"},    8'(bus.round_over), 8'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic restart(input string tag);
    bus.start = 1'b0;
    cycle({tag, "_lo"});
    bus.start = 1'b1;
    cycle({tag, "_hi"});
    check({tag, "/in_fight"}, 8'(bus.game_state), 8'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    set_hits(0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    do_reset("init");

    // Idle: nothing changes without a start edge, hits ignored.
    for (int i = 0; i < 20; i++) begin
      set_hits(i % 3 == 0, 7, i % 4 == 0, 9);
      cycle("idle");
    end
    set_hits(0, 0, 0, 0);

    // Start and knockout by player 1.
    bus.start = 1'b1;
    cycle("ko_start");
    check("ko/fight", 8'(bus.game_state), 8'd0);
    for (int i = 0; i < 10; i++) begin
      set_hits(1, 10, 0, 0);
      cycle("ko_hit");
    end
    check("ko/p2h_zero", 8'(bus.p2_health),  8'd0);
    check("ko/p1_win",   8'(bus.game_state), 8'd1);
    check("ko/ro_pulse", 8'(bus.round_over), 8'd1);
    for (int i = 0; i < 3; i++) cycle("ko_after");
    check("ko/ro_cleared", 8'(bus.round_over), 8'd0);
    check("ko/p1h_frozen", 8'(bus.p1_health),  8'(MAX));
    set_hits(0, 0, 0, 0);

    // Saturation and simultaneous knockout.
    restart("sat");
    for (int i = 0; i < 6; i++) begin
      set_hits(1, 15, 1, 15);
      cycle("sat_dn");
    end
    set_hits(1, 5, 1, 5);
    cycle("sat_five");
    check("sat/p1h5", 8'(bus.p1_health), 8'd5);
    check("sat/p2h5", 8'(bus.p2_health), 8'd5);
    set_hits(1, 9, 1, 15);
    cycle("sat_ko");
    check("sat/p1h0",  8'(bus.p1_health),  8'd0);
    check("sat/p2h0",  8'(bus.p2_health),  8'd0);
    check("sat/draw",  8'(bus.game_state), 8'd3);
    check("sat/ro",    8'(bus.round_over), 8'd1);
    set_hits(0, 0, 0, 0);
    cycle("sat_post");
    check("sat/ro_one", 8'(bus.round_over), 8'd0);

    // Timeout with player 2 ahead.
    restart("tmo");
    set_hits(0, 0, 1, 4);
    cycle("tmo_hit");
    set_hits(0, 0, 0, 0);
    for (int i = 0; i < 29; i++) cycle("tmo_run");
    check("tmo/p2_win", 8'(bus.game_state), 8'd2);
    check("tmo/p1h96",  8'(bus.p1_health),  8'd96);
    check("tmo/time0",  8'(bus.time_left),  8'd0);
    for (int i = 0; i < 5; i++) cycle("tmo_frozen");
    check("tmo/p1h_hold", 8'(bus.p1_health), 8'd96);

    // Tie on timeout, start held high through the result: one restart only.
    restart("tie");
    for (int i = 0; i < 40; i++) cycle("tie_run");
    check("tie/draw", 8'(bus.game_state), 8'd3);
    check("tie/p1h",  8'(bus.p1_health),  8'(MAX));

    // Start pulse mid-fight is ignored; reset mid-fight aborts.
    restart("mid");
    set_hits(1, 3, 0, 0);
    cycle("mid_hit");
    set_hits(0, 0, 0, 0);
    bus.start = 1'b0;
    cycle("mid_lo");
    bus.start = 1'b1;
    cycle("mid_pulse");
    bus.start = 1'b0;
    cycle("mid_lo2");
    check("mid/p2h97", 8'(bus.p2_health),  8'd97);
    check("mid/fight", 8'(bus.game_state), 8'd0);
    do_reset("mid");
    cycle("mid_after_rst");
    check("mid/no_ro", 8'(bus.round_over), 8'd0);

    // Randomized rounds.
    for (int r = 0; r < 30; r++) begin
      restart("rnd");
      for (int c = 0; c < 40; c++) begin
        set_hits($urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)));
        if ($urandom_range(0, 7) == 0) bus.start = ~bus.start;
        cycle("rnd_cyc");
      end
      set_hits(0, 0, 0, 0);
      if (r % 5 == 4) begin
        bus.start = 1'b0;
        do_reset("rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
